pe_tile_sequencer: RTL and testbench
====================================

// Module: pe_tile_sequencer
// PURPOSE
//  Sequences one convolution tile through the PE_ROWS x PE_COLS MAC array, channel by channel.
//  Per channel: loads R weight rows, streams PE_COLS input beats, waits for the active R x S
//  MAC region to finish, then writes the psums to output storage.
//  Sits between the AXI-side buffer fetch logic and the PE array/output storage.
//  Clears the MAC accumulators once per tile; psums accumulate across all C channels.
// PARAMETERS
//  PE_ROWS         5   MAC array rows
//  PE_COLS         5   MAC array columns
//  MAC_PIPE_DEPTH  2   MAC pipeline depth; sets the minimum number of DRAIN cycles
// PORTS
//  CLK               in   1                 clock
//  RESET             in   1                 synchronous reset, active-high
//  start             in   1                 tile start pulse; sampled only in IDLE
//  param_R           in   4                 filter height (active PE rows)
//  param_S           in   4                 filter width (active PE cols)
//  param_C           in   12                input channels to accumulate
//  w_valid / w_ready in/out 1               weight-row handshake
//  in_valid / in_ready in/out 1             input-beat handshake
//  mac_done          in   PE_ROWS*PE_COLS   per-PE done flags, index r*PE_COLS+c
//  weight_row_wr_ctrl out 3                 weight row being written
//  weight_wr_en      out  1                 weight row write strobe
//  stall             out  1                 global MAC stall
//  mac_clear         out  1                 accumulator clear pulse
//  out_wr_en         out  1                 output storage write enable
//  ch_idx            out  12                current channel index
//  busy / done / err out  1                 status; done and err are 1-cycle pulses
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 except stall=1. Counters cleared. Reset mid-tile aborts
//    the tile with no done pulse.
//  - Outputs are registered or decoded from the registered state. No comb path from in_valid
//    or w_valid to the ready outputs.
//  - IDLE, start=1:
//      * R=0, S=0, C=0, R>PE_ROWS or S>PE_COLS -> err=1 next cycle; stay IDLE.
//      * Otherwise latch R/S/C, pulse mac_clear=1 for one cycle, go to LOAD_W.
//  - start while busy is ignored. Latched params are not affected by param_* changes mid-tile.
//  - LOAD_W: w_ready=1, stall=1. Each w_valid&w_ready: weight_wr_en=1 in the same cycle,
//    weight_row_wr_ctrl=row count, row count increments. After row R-1 -> STREAM.
//  - STREAM: in_ready=1; stall = ~in_valid. Counts in_valid&in_ready beats.
//    After PE_COLS beats -> DRAIN.
//  - DRAIN: stall=0, in_ready=0.
//      * mask = PE bits with r<R and c<S.
//      * Exit when (mac_done & mask)==mask AND at least MAC_PIPE_DEPTH cycles have been
//        spent in DRAIN -> WRITE.
//      * Unmasked bits are ignored.
//  - WRITE: out_wr_en=1 for exactly one cycle.
//      * ch_idx==C-1 -> DONE; otherwise ch_idx++ -> LOAD_W.
//      * No mac_clear between channels.
//  - DONE: done=1 for one cycle, ch_idx cleared -> IDLE.
//  - busy=1 in every state except IDLE.
//  - Counters: row 3b, beat 3b, ch 12b. ch_idx never wraps because it is bounded by C-1.
//  - Handshakes outside their own states are ignored; ready stays 0.
// TESTING
//  1. R=3,S=3,C=1, weights and inputs always valid, mac_done all-ones:
//     3 weight_wr_en (rows 0,1,2) -> 5 beats -> >=2 DRAIN cycles -> 1 out_wr_en -> done pulse.
//  2. R=5,S=5,C=4: mac_clear once only; 4 out_wr_en with ch_idx 0..3; done after the 4th.
//  3. In STREAM, in_valid toggles 1,0,0,1,...:
//     stall=1 exactly in the in_valid=0 cycles; beat count is unaffected.
//  4. R=2,S=2: set mac_done bits only for r<2,c<2 -> DRAIN exits.
//     Clear bit (0,0) -> sequencer waits in DRAIN.
//  5. start with R=6, then with C=0: err pulse each time, busy stays 0.
//     start asserted while busy: ignored.
//  6. RESET asserted in DRAIN with C=3: next cycle IDLE, ch_idx=0, stall=1, no done.
//     A fresh start then completes normally.

Source files
------------

// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer
// Walks one convolution tile through the PE array one input channel at a time:
// weight rows are loaded, PE_COLS input beats are streamed, the active R x S MAC
// region is drained, and the accumulated psums are written out. Accumulators are
// cleared once when the tile is accepted and accumulate across all C channels.
module pe_tile_sequencer #(
    parameter int PE_ROWS        = 5,
    parameter int PE_COLS        = 5,
    parameter int MAC_PIPE_DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         start,
    input  logic [3:0]                   param_R,
    input  logic [3:0]                   param_S,
    input  logic [11:0]                  param_C,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PE_ROWS*PE_COLS-1:0]   mac_done,
    output logic [2:0]                   weight_row_wr_ctrl,
    output logic                         weight_wr_en,
    output logic                         stall,
    output logic                         mac_clear,
    output logic                         out_wr_en,
    output logic [11:0]                  ch_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int NUM_PE  = PE_ROWS * PE_COLS;
    // The drain counter only has to reach MAC_PIPE_DEPTH-1 and then saturates.
    localparam int DRAIN_W = (MAC_PIPE_DEPTH > 1) ? $clog2(MAC_PIPE_DEPTH) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_MIN = DRAIN_W'(MAC_PIPE_DEPTH - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE = DRAIN_W'(1);
    localparam logic [3:0]         MAX_R     = 4'(PE_ROWS);
    localparam logic [3:0]         MAX_S     = 4'(PE_COLS);
    localparam logic [2:0]         LAST_BEAT = 3'(PE_COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Bit r*PE_COLS+c is set when PE (r,c) lies inside the active R x S region.
    function automatic logic [NUM_PE-1:0] build_mask(input logic [3:0] r, input logic [3:0] s);
        logic [NUM_PE-1:0] m;
        m = '0;
        for (int i = 0; i < PE_ROWS; i++) begin
            for (int j = 0; j < PE_COLS; j++) begin
                if ((4'(i) < r) && (4'(j) < s)) begin
                    m[i*PE_COLS + j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    state_t               state_r;
    logic [3:0]           r_lat_r;
    logic [11:0]          c_lat_r;
    logic [NUM_PE-1:0]    mask_r;
    logic [2:0]           row_cnt_r;
    logic [2:0]           beat_cnt_r;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [11:0]          ch_idx_r;
    logic                 w_ready_r;
    logic                 in_ready_r;
    logic                 stall_r;
    logic                 busy_r;
    logic                 mac_clear_r;
    logic                 out_wr_en_r;
    logic                 done_r;
    logic                 err_r;

    logic                 params_bad_s;
    logic                 mask_met_s;
    logic                 drain_min_met_s;
    logic                 last_row_s;
    logic                 last_beat_s;
    logic                 last_ch_s;

    assign params_bad_s    = (param_R == 4'd0) || (param_S == 4'd0) || (param_C == 12'd0) ||
                             (param_R > MAX_R) || (param_S > MAX_S);
    // PEs outside the active region never gate the drain exit.
    assign mask_met_s      = ((mac_done & mask_r) == mask_r);
    assign drain_min_met_s = (drain_cnt_r == DRAIN_MIN);
    assign last_row_s      = ({1'b0, row_cnt_r} == (r_lat_r - 4'd1));
    assign last_beat_s     = (beat_cnt_r == LAST_BEAT);
    assign last_ch_s       = (ch_idx_r == (c_lat_r - 12'd1));

    // Ready flags come straight from registers; only the write strobe and the
    // streaming stall follow the incoming valid within the cycle.
    assign w_ready            = w_ready_r;
    assign in_ready           = in_ready_r;
    assign weight_wr_en       = w_ready_r & w_valid;
    assign weight_row_wr_ctrl = row_cnt_r;
    assign stall              = in_ready_r ? ~in_valid : stall_r;
    assign mac_clear          = mac_clear_r;
    assign out_wr_en          = out_wr_en_r;
    assign ch_idx             = ch_idx_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign err                = err_r;

    // Tile sequencing FSM with its registered status outputs and counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            r_lat_r     <= 4'd0;
            c_lat_r     <= 12'd0;
            mask_r      <= '0;
            row_cnt_r   <= 3'd0;
            beat_cnt_r  <= 3'd0;
            drain_cnt_r <= '0;
            ch_idx_r    <= 12'd0;
            w_ready_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            stall_r     <= 1'b1;
            busy_r      <= 1'b0;
            mac_clear_r <= 1'b0;
            out_wr_en_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mac_clear_r <= 1'b0;
            out_wr_en_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (params_bad_s) begin
                            err_r <= 1'b1;
                        end else begin
                            r_lat_r     <= param_R;
                            c_lat_r     <= param_C;
                            mask_r      <= build_mask(param_R, param_S);
                            row_cnt_r   <= 3'd0;
                            beat_cnt_r  <= 3'd0;
                            ch_idx_r    <= 12'd0;
                            mac_clear_r <= 1'b1;
                            w_ready_r   <= 1'b1;
                            stall_r     <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_LOAD_W;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_valid) begin
                        if (last_row_s) begin
                            row_cnt_r  <= 3'd0;
                            beat_cnt_r <= 3'd0;
                            w_ready_r  <= 1'b0;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_STREAM;
                        end else begin
                            row_cnt_r <= row_cnt_r + 3'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (in_valid) begin
                        if (last_beat_s) begin
                            beat_cnt_r  <= 3'd0;
                            drain_cnt_r <= '0;
                            in_ready_r  <= 1'b0;
                            stall_r     <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 3'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mask_met_s && drain_min_met_s) begin
                        out_wr_en_r <= 1'b1;
                        stall_r     <= 1'b1;
                        state_r     <= ST_WRITE;
                    end else if (!drain_min_met_s) begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
                    end
                end
                ST_WRITE: begin
                    if (last_ch_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        ch_idx_r  <= ch_idx_r + 12'd1;
                        w_ready_r <= 1'b1;
                        state_r   <= ST_LOAD_W;
                    end
                end
                ST_DONE: begin
                    ch_idx_r <= 12'd0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ch_idx_r   <= 12'd0;
                    w_ready_r  <= 1'b0;
                    in_ready_r <= 1'b0;
                    stall_r    <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// tb_pe_tile_sequencer
// Table of tile configurations (valid and illegal) plus randomized tiles, each
// checked against an event-level model: per channel R weight-row writes, PE_COLS
// beats and one output write, with drain exit timing derived from mac_done.
module tb_pe_tile_sequencer;

    localparam int NR    = 5;
    localparam int NC    = 5;
    localparam int DEPTH = 2;
    localparam int NPE   = NR * NC;

    logic             CLK;
    logic             RESET;
    logic             start;
    logic [3:0]       param_R;
    logic [3:0]       param_S;
    logic [11:0]      param_C;
    logic             w_valid;
    logic             w_ready;
    logic             in_valid;
    logic             in_ready;
    logic [NPE-1:0]   mac_done;
    logic [2:0]       weight_row_wr_ctrl;
    logic             weight_wr_en;
    logic             stall;
    logic             mac_clear;
    logic             out_wr_en;
    logic [11:0]      ch_idx;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  s;
        logic [11:0] c;
        int          mode;
        logic        exp_err;
    } vec_t;

    vec_t tbl[14];

    pe_tile_sequencer #(
        .PE_ROWS        (NR),
        .PE_COLS        (NC),
        .MAC_PIPE_DEPTH (DEPTH)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .start              (start),
        .param_R            (param_R),
        .param_S            (param_S),
        .param_C            (param_C),
        .w_valid            (w_valid),
        .w_ready            (w_ready),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .mac_done           (mac_done),
        .weight_row_wr_ctrl (weight_row_wr_ctrl),
        .weight_wr_en       (weight_wr_en),
        .stall              (stall),
        .mac_clear          (mac_clear),
        .out_wr_en          (out_wr_en),
        .ch_idx             (ch_idx),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    // 10 ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NPE-1:0] region_mask(input int r, input int s);
        logic [NPE-1:0] m;
        m = '0;
        for (int rr = 0; rr < NR; rr++) begin
            for (int cc = 0; cc < NC; cc++) begin
                if (rr < r && cc < s) m[rr*NC + cc] = 1'b1;
            end
        end
        return m;
    endfunction

    // kind 1 = weight row write, 2 = input beat, 3 = output write
    function automatic int enc(input int kind, input int row, input int ch);
        return kind * 1000000 + row * 10000 + ch;
    endfunction

    task automatic idle_inputs();
        start    = 1'b0;
        w_valid  = 1'b0;
        in_valid = 1'b0;
        mac_done = '0;
    endtask

    // Illegal configuration: one-cycle err pulse, never leaves IDLE.
    task automatic run_err(input int r, input int s, input int c, input logic exp_err);
        start   = 1'b1;
        param_R = 4'(r);
        param_S = 4'(s);
        param_C = 12'(c);
        #1;
        @(negedge CLK);
        start = 1'b0;
        #1;
        check("err_pulse", err, exp_err);
        check("err_busy", busy, 0);
        check("err_mac_clear", mac_clear, 0);
        @(negedge CLK);
        #1;
        check("err_one_cycle", err, 0);
        check("err_still_idle", busy, 0);
        @(negedge CLK);
    endtask

    // One full tile; mode 0 always valid, 1 random, 2 in_valid 1,0,0 pattern, 3 PE(0,0) late.
    task automatic run_tile(input int r, input int s, input int c, input int mode);
        logic [NPE-1:0] m;
        int   exp_q[$];
        int   obs_q[$];
        bit   cov_q[$];
        int   t, drain_start, beats, sc, clears, clear_t, dones, t_done, t_last_out, errs, exp_t, n;
        bit   finished;
        m = region_mask(r, s);
        for (int ch = 0; ch < c; ch++) begin
            for (int row = 0; row < r; row++) exp_q.push_back(enc(1, row, ch));
            for (int b = 0; b < NC; b++) exp_q.push_back(enc(2, 0, ch));
            exp_q.push_back(enc(3, 0, ch));
        end
        idle_inputs();
        start   = 1'b1;
        param_R = 4'(r);
        param_S = 4'(s);
        param_C = 12'(c);
        #1;
        check("start_idle_busy", busy, 0);
        @(negedge CLK);
        start = 1'b0;
        t = 0; drain_start = -1; beats = 0; sc = 0; clears = 0; clear_t = -1;
        dones = 0; t_done = -1; t_last_out = -1; errs = 0; finished = 1'b0;
        while (!finished && t < 3000) begin
            case (mode)
                0: begin
                    w_valid = 1'b1; in_valid = 1'b1; mac_done = '1;
                end
                1: begin
                    w_valid  = (($urandom % 3) != 0);
                    in_valid = (($urandom % 2) == 1);
                    mac_done = (($urandom % 3) == 0) ? (m | NPE'($urandom)) : NPE'($urandom);
                    start    = (($urandom % 6) == 0);
                    param_R  = 4'($urandom);
                    param_S  = 4'($urandom);
                    param_C  = 12'($urandom % 8);
                end
                2: begin
                    w_valid = 1'b1; in_valid = ((sc % 3) == 0); mac_done = '1;
                end
                default: begin
                    w_valid  = 1'b1;
                    in_valid = 1'b1;
                    mac_done = (drain_start >= 0 && t >= drain_start + 5) ? m : (m & ~NPE'(1));
                end
            endcase
            #1;
            if (weight_wr_en) obs_q.push_back(enc(1, int'(weight_row_wr_ctrl), int'(ch_idx)));
            if (w_ready) check("stall_load", stall, 1);
            if (in_ready) begin
                check("stall_stream", stall, !in_valid);
                sc++;
                if (in_valid) begin
                    obs_q.push_back(enc(2, 0, int'(ch_idx)));
                    beats++;
                    if (beats == NC) begin
                        beats = 0;
                        sc = 0;
                        drain_start = t + 1;
                    end
                end
            end
            cov_q.push_back((mac_done & m) == m);
            if (out_wr_en) begin
                obs_q.push_back(enc(3, 0, int'(ch_idx)));
                t_last_out = t;
                exp_t = -1;
                if (drain_start >= 0) begin
                    for (int k = drain_start + DEPTH - 1; k < t && exp_t < 0; k++) begin
                        if (cov_q[k]) exp_t = k + 1;
                    end
                end
                check("drain_exit_cycle", t, exp_t);
                drain_start = -1;
            end else if (drain_start >= 0 && t >= drain_start) begin
                check("drain_stall", stall, 0);
                check("drain_in_ready", in_ready, 0);
            end
            if (mac_clear) begin clears++; clear_t = t; end
            if (err) errs++;
            if (done) begin dones++; t_done = t; finished = 1'b1; end
            @(negedge CLK);
            t++;
        end
        idle_inputs();
        check("tile_finished", finished, 1);
        check("mac_clear_count", clears, 1);
        check("mac_clear_cycle", clear_t, 0);
        check("tile_err_count", errs, 0);
        check("done_count", dones, 1);
        check("done_after_last_write", t_done, t_last_out + 1);
        check("event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("event_seq", obs_q[i], exp_q[i]);
        #1;
        check("post_idle_busy", busy, 0);
        check("post_idle_ch_idx", ch_idx, 0);
        check("post_idle_stall", stall, 1);
        @(negedge CLK);
    endtask

    // Abort a C=3 tile while it waits in DRAIN, then confirm a clean restart.
    task automatic run_reset_in_drain();
        int seen, after, dones;
        idle_inputs();
        start = 1'b1; param_R = 4'd2; param_S = 4'd2; param_C = 12'd3;
        #1;
        @(negedge CLK);
        start = 1'b0; w_valid = 1'b1; in_valid = 1'b1; mac_done = '0;
        seen = 0; after = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (in_ready) seen++;
            if (seen >= NC && !in_ready) after++;
            @(negedge CLK);
            if (after >= 3) break;
        end
        #1;
        check("pre_reset_in_drain", {busy, in_ready, w_ready, stall}, 4'b1000);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        @(negedge CLK);
        RESET = 1'b0;
        idle_inputs();
        #1;
        check("rst_drain_busy", busy, 0);
        check("rst_drain_ch_idx", ch_idx, 0);
        check("rst_drain_stall", stall, 1);
        check("rst_drain_done", done, 0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            if (done || busy) dones++;
        end
        check("rst_drain_quiet", dones, 0);
        @(negedge CLK);
        run_tile(2, 2, 3, 0);
    endtask

    initial begin
        tbl[0]  = '{4'd3, 4'd3, 12'd1, 0, 1'b0};
        tbl[1]  = '{4'd5, 4'd5, 12'd4, 0, 1'b0};
        tbl[2]  = '{4'd4, 4'd5, 12'd2, 2, 1'b0};
        tbl[3]  = '{4'd2, 4'd2, 12'd1, 3, 1'b0};
        tbl[4]  = '{4'd6, 4'd3, 12'd1, 0, 1'b1};
        tbl[5]  = '{4'd3, 4'd3, 12'd0, 0, 1'b1};
        tbl[6]  = '{4'd0, 4'd2, 12'd2, 0, 1'b1};
        tbl[7]  = '{4'd2, 4'd0, 12'd2, 0, 1'b1};
        tbl[8]  = '{4'd5, 4'd6, 12'd1, 0, 1'b1};
        tbl[9]  = '{4'd1, 4'd1, 12'd1, 0, 1'b0};
        tbl[10] = '{4'd5, 4'd5, 12'd2, 1, 1'b0};
        tbl[11] = '{4'd1, 4'd5, 12'd3, 2, 1'b0};
        tbl[12] = '{4'd15, 4'd15, 12'd4095, 0, 1'b1};
        tbl[13] = '{4'd5, 4'd1, 12'd2, 1, 1'b0};

        RESET = 1'b1;
        param_R = 4'd0; param_S = 4'd0; param_C = 12'd0;
        idle_inputs();
        repeat (3) @(negedge CLK);
        #1;
        check("rst_stall", stall, 1);
        check("rst_busy", busy, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_weight_wr_en", weight_wr_en, 0);
        check("rst_row_ctrl", weight_row_wr_ctrl, 0);
        check("rst_mac_clear", mac_clear, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_ch_idx", ch_idx, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].exp_err) begin
                run_err(int'(tbl[i].r), int'(tbl[i].s), int'(tbl[i].c), 1'b1);
            end else begin
                run_tile(int'(tbl[i].r), int'(tbl[i].s), int'(tbl[i].c), tbl[i].mode);
            end
        end

        for (int i = 0; i < 10; i++) begin
            run_tile(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                     int'($urandom_range(1, 4)), 1);
        end

        run_reset_in_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
